// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter sharing the VGA drawing datapath among sprite channels,
// with done/timeout release and game-phase masking of eligible channels.
module sprite_draw_arbiter #(
  parameter int                 N_CH       = 4,
  parameter int                 STATE_W    = 4,
  parameter logic [STATE_W-1:0] IDLE_STATE = {STATE_W{1'b1}},
  parameter int                 TIMEOUT    = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic                      collision,
  input  logic [N_CH-1:0]           ch_req,
  input  logic [N_CH-1:0]           ch_done,
  input  logic [N_CH*STATE_W-1:0]   ch_state,
  output logic [N_CH-1:0]           grant,
  output logic [$clog2(N_CH)-1:0]   cur_ch,
  output logic [STATE_W-1:0]        cur_state,
  output logic                      started,
  output logic                      game_over,
  output logic                      timeout_err
);

  localparam int          PTR_W  = $clog2(N_CH);
  localparam int          CNT_W  = $clog2(TIMEOUT);
  localparam int unsigned NCH_U  = N_CH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(N_CH - 1);

  typedef enum logic [1:0] {
    PH_WAIT,
    PH_RUN,
    PH_OVER
  } phase_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_e;

  phase_e             phase_q, phase_d;
  arb_e               arb_q, arb_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   cur_ch_q, cur_ch_d;
  logic [STATE_W-1:0] cur_state_q, cur_state_d;
  logic               terr_q, terr_d;

  logic [STATE_W-1:0] st_arr [N_CH];
  logic [N_CH-1:0]    mask;
  logic [N_CH-1:0]    cand;
  logic [PTR_W-1:0]   search_start;
  logic [PTR_W:0]     pick;
  logic               done_hit;
  logic               tmo_hit;
  logic               release_g;

  // First set bit of cand at or above start, wrapping; MSB flags a hit.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_CH-1:0]  c,
                                             input logic [PTR_W-1:0] start);
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx_w;
    int unsigned      idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NCH_U; i++) begin
      idx = 32'(start) + i;
      if (idx >= NCH_U) idx = idx - NCH_U;
      idx_w = PTR_W'(idx);
      if (!found && c[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NCH_U; i++) begin
      st_arr[i] = ch_state[i*STATE_W +: STATE_W];
    end
  end

  always_comb begin
    phase_d  = phase_q;
    arb_d    = arb_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    cur_ch_d = cur_ch_q;
    terr_d   = terr_q;

    cur_state_d = (arb_q == ARB_BUSY) ? st_arr[cur_ch_q] : IDLE_STATE;

    // Mask comes from the pre-edge phase, so a phase change and an
    // arbitration decision at the same edge see the old eligibility.
    mask = (phase_q == PH_RUN) ? '1 : N_CH'(1);

    done_hit  = (arb_q == ARB_BUSY) && ch_done[cur_ch_q];
    tmo_hit   = (arb_q == ARB_BUSY) && !done_hit && (cnt_q == CNT_LAST);
    release_g = done_hit || tmo_hit;

    // On release the search restarts just past the finishing channel and
    // excludes it, giving back-to-back grants without an idle cycle.
    search_start = ptr_q;
    cand         = ch_req & mask;
    if (release_g) begin
      search_start = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
      ptr_d        = search_start;
      cand         = ch_req & mask & ~grant_q;
    end
    pick = rr_pick(cand, search_start);

    if (arb_q == ARB_IDLE || release_g) begin
      cnt_d = '0;
      if (pick[PTR_W]) begin
        arb_d    = ARB_BUSY;
        cur_ch_d = pick[PTR_W-1:0];
        grant_d  = N_CH'(1) << pick[PTR_W-1:0];
      end else begin
        arb_d   = ARB_IDLE;
        grant_d = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (tmo_hit) terr_d = 1'b1;

    unique case (phase_q)
      PH_WAIT: if (!go)      phase_d = PH_RUN;
      PH_RUN:  if (collision) phase_d = PH_OVER;
      PH_OVER: phase_d = PH_OVER;
      default: phase_d = PH_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_WAIT;
      arb_q       <= ARB_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      cur_ch_q    <= '0;
      cur_state_q <= IDLE_STATE;
      terr_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      arb_q       <= arb_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      cur_ch_q    <= cur_ch_d;
      cur_state_q <= cur_state_d;
      terr_q      <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign cur_ch      = cur_ch_q;
  assign cur_state   = cur_state_q;
  assign started     = (phase_q != PH_WAIT);
  assign game_over   = (phase_q == PH_OVER);
  assign timeout_err = terr_q;

endmodule
